// File: rtl/id_ex_control_stage.sv
// id_ex_control_stage
//   Decodes the IF/ID instruction into the main control signals and the
//   ALUOp/Funct pair for the EX-stage ALU control decoder. Registers them
//   into the ID/EX pipeline register. Inserts a one-cycle bubble on a
//   load-use hazard, honours downstream stall and flush, and keeps a
//   saturating count of accepted illegal instructions.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   id_instr/id_valid  instruction word from IF/ID and its valid bit
//   stall              hold the ID/EX register
//   flush              load a bubble into ID/EX
//   hazard_stall       combinational: PC and IF/ID must hold this cycle
//   ex_*               ID/EX register contents (control, fields, immediate)
//   ill_count          saturating illegal-instruction count
module id_ex_control_stage #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          id_instr,
  input  logic                 id_valid,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 hazard_stall,
  output logic                 ex_valid,
  output logic [2:0]           ex_ALUOp,
  output logic [5:0]           ex_Funct,
  output logic                 ex_RegWrite,
  output logic                 ex_RegDst,
  output logic                 ex_ALUSrc,
  output logic                 ex_MemRead,
  output logic                 ex_MemWrite,
  output logic                 ex_MemtoReg,
  output logic                 ex_Branch,
  output logic [4:0]           ex_rs,
  output logic [4:0]           ex_rt,
  output logic [4:0]           ex_rd,
  output logic [4:0]           ex_shamt,
  output logic [31:0]          ex_imm,
  output logic [ILL_CNT_W-1:0] ill_count
);

  typedef struct packed {
    logic        valid;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic        reg_write;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm;
  } ex_t;

  ex_t                  dec_p0;
  ex_t                  ex_p1;
  logic                 legal_p0;
  logic                 uses_rt_p0;
  logic                 hz_p0;
  logic [ILL_CNT_W-1:0] ill_p1;
  logic [5:0]           op_p0;
  logic [5:0]           funct_p0;

  function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign op_p0    = id_instr[31:26];
  assign funct_p0 = id_instr[5:0];

  // ---- stage p0: decode ----
  always_comb begin
    dec_p0       = '0;
    legal_p0     = 1'b1;
    uses_rt_p0   = 1'b0;
    dec_p0.valid = 1'b1;
    dec_p0.funct = funct_p0;
    dec_p0.rs    = id_instr[25:21];
    dec_p0.rt    = id_instr[20:16];
    dec_p0.rd    = id_instr[15:11];
    dec_p0.shamt = id_instr[10:6];
    dec_p0.imm   = {{16{id_instr[15]}}, id_instr[15:0]};
    case (op_p0)
      6'b000000: begin
        uses_rt_p0       = 1'b1;
        dec_p0.alu_op    = 3'b110;
        dec_p0.reg_write = 1'b1;
        dec_p0.reg_dst   = 1'b1;
        case (funct_p0)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
          6'b100111, 6'b100110, 6'b000000, 6'b000010, 6'b000011: legal_p0 = 1'b1;
          default: legal_p0 = 1'b0;
        endcase
      end
      6'b100011: begin
        dec_p0.alu_op     = 3'b000;
        dec_p0.reg_write  = 1'b1;
        dec_p0.alu_src    = 1'b1;
        dec_p0.mem_read   = 1'b1;
        dec_p0.mem_to_reg = 1'b1;
      end
      6'b101011: begin
        uses_rt_p0       = 1'b1;
        dec_p0.alu_op    = 3'b000;
        dec_p0.alu_src   = 1'b1;
        dec_p0.mem_write = 1'b1;
      end
      6'b000100: begin
        uses_rt_p0    = 1'b1;
        dec_p0.alu_op = 3'b001;
        dec_p0.branch = 1'b1;
      end
      6'b001000: begin
        dec_p0.alu_op    = 3'b000;
        dec_p0.reg_write = 1'b1;
        dec_p0.alu_src   = 1'b1;
      end
      6'b001010: begin
        dec_p0.alu_op    = 3'b100;
        dec_p0.reg_write = 1'b1;
        dec_p0.alu_src   = 1'b1;
      end
      6'b001100, 6'b001101, 6'b001110: begin
        // logical immediates are zero-extended
        dec_p0.alu_op    = (op_p0 == 6'b001100) ? 3'b010 :
                           (op_p0 == 6'b001101) ? 3'b011 : 3'b101;
        dec_p0.reg_write = 1'b1;
        dec_p0.alu_src   = 1'b1;
        dec_p0.imm       = {16'h0000, id_instr[15:0]};
      end
      default: legal_p0 = 1'b0;
    endcase
  end

  // Load-use: the load in EX writes a register this instruction reads.
  // Writes to $0 never create a dependency.
  assign hz_p0 = ex_p1.valid & ex_p1.mem_read & (ex_p1.rt != 5'd0) & id_valid & legal_p0 &
                 ((dec_p0.rs == ex_p1.rt) | (uses_rt_p0 & (dec_p0.rt == ex_p1.rt)));

  assign hazard_stall = hz_p0 & ~flush & ~stall;

  // ---- stage p1: ID/EX register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_p1  <= '0;
      ill_p1 <= '0;
    end else if (flush) begin
      ex_p1 <= '0;
    end else if (stall) begin
      ex_p1 <= ex_p1;
    end else if (hz_p0 || !id_valid) begin
      ex_p1 <= '0;
    end else if (!legal_p0) begin
      ex_p1  <= '0;
      ill_p1 <= sat_inc(ill_p1);
    end else begin
      ex_p1 <= dec_p0;
    end
  end

  assign ex_valid    = ex_p1.valid;
  assign ex_ALUOp    = ex_p1.alu_op;
  assign ex_Funct    = ex_p1.funct;
  assign ex_RegWrite = ex_p1.reg_write;
  assign ex_RegDst   = ex_p1.reg_dst;
  assign ex_ALUSrc   = ex_p1.alu_src;
  assign ex_MemRead  = ex_p1.mem_read;
  assign ex_MemWrite = ex_p1.mem_write;
  assign ex_MemtoReg = ex_p1.mem_to_reg;
  assign ex_Branch   = ex_p1.branch;
  assign ex_rs       = ex_p1.rs;
  assign ex_rt       = ex_p1.rt;
  assign ex_rd       = ex_p1.rd;
  assign ex_shamt    = ex_p1.shamt;
  assign ex_imm      = ex_p1.imm;
  assign ill_count   = ill_p1;

endmodule

// File: doc/id_ex_control_stage.md
Name: id_ex_control_stage

Overview:
- Decode-side producer of the ALUOp/Funct pair consumed by the EX-stage ALU control decoder.
- Decodes the IF/ID instruction into main control signals and registers them into the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles itself. Honours external stall and flush, and counts illegal instructions.

Parameters:
- ILL_CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_instr  in  32  instruction word from IF/ID
- id_valid  in  1  id_instr holds a real instruction
- stall  in  1  downstream freeze; ID/EX register holds its contents
- flush  in  1  branch/exception flush; loads a bubble into ID/EX
- hazard_stall  out  1  combinational; tells PC and IF/ID to hold this cycle
- ex_valid  out  1  ID/EX slot holds a real instruction
- ex_ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor, 110 R-type (use Funct)
- ex_Funct  out  6  instr[5:0]
- ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch  out  1 each  main control
- ex_rs, ex_rt, ex_rd, ex_shamt  out  5 each  instr[25:21], [20:16], [15:11], [10:6]
- ex_imm  out  32  sign-extended instr[15:0]; zero-extended for andi/ori/xori
- ill_count  out  ILL_CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset (async, active-high): every ex_* output = 0, ill_count = 0. hazard_stall follows its equation, which evaluates to 0 because ex_valid = 0.
- Decode table (op = instr[31:26]); each entry lists ALUOp, then the flags that are 1; all other flags are 0:
  - 000000 R: 110; RegWrite, RegDst
  - 100011 lw: 000; RegWrite, ALUSrc, MemRead, MemtoReg
  - 101011 sw: 000; ALUSrc, MemWrite
  - 000100 beq: 001; Branch
  - 001000 addi: 000; RegWrite, ALUSrc
  - 001100 andi: 010; RegWrite, ALUSrc, zero-extended imm
  - 001101 ori: 011; same as andi
  - 001010 slti: 100; RegWrite, ALUSrc
  - 001110 xori: 101; same as andi
- Supported R-type funct values: 100000, 100010, 100100, 100101, 101010, 100111, 100110, 000000, 000010, 000011.
- Illegal instruction: any other opcode, or op = 000000 with any other funct.
  - Loads as a bubble: ex_valid = 0, all flags 0.
  - ill_count increments, saturating at all ones.
- Bubble: ex_valid = 0 and all control flags 0. Field and data outputs (ex_ALUOp, ex_Funct, ex_rs, ex_rt, ex_rd, ex_shamt, ex_imm) = 0.
- Load-use hazard condition `hz`: ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & legal & (rs == ex_rt | (uses_rt & rt == ex_rt)).
  - uses_rt is true for R-type, sw and beq.
- hazard_stall = hz & ~flush & ~stall.
- Register update priority at each rising clk edge:
  1. flush -> bubble.
  2. stall -> hold all ex_* outputs and ill_count.
  3. hz -> bubble. Because hazard_stall holds IF/ID, the same instruction is re-presented next cycle and passes, since the bubble clears ex_MemRead.
  4. id_valid = 0 -> bubble.
  5. Otherwise load the decoded instruction.
- ill_count increments only when case 5 loads an illegal instruction. A flushed, stalled or hazarded illegal instruction is not counted.
- Latency: 1 cycle from id_instr to ex_* outputs. Hazard costs exactly 1 bubble.
- A reset asserted mid-stall or mid-hazard clears everything immediately, with no waiting for a clock edge.

Test Plan:
- Reset, then id_instr = 0x00221820 (add $3,$1,$2) with id_valid = 1 -> next cycle: ex_valid = 1, ALUOp = 110, Funct = 100000, RegWrite = 1, RegDst = 1, rs = 1, rt = 2, rd = 3.
- 0x8C220004 (lw $2,4($1)), then 0x00421820 (add $3,$2,$2):
  - cycle 2: hazard_stall = 1 and a bubble enters (ex_valid = 0).
  - cycle 3: the add loads with ALUOp = 110, and hazard_stall = 0.
- lw $2 followed by 0x00011820 (add $3,$0,$1) -> no hazard. Then lw $0,0($1) followed by an instruction using rs = 0 -> no hazard.
- 0x3022FFFF (andi) -> ALUOp = 010, ex_imm = 0x0000FFFF. 0x2022FFFF (addi) -> ALUOp = 000, ex_imm = 0xFFFFFFFF. 0x10220003 (beq) -> ALUOp = 001, Branch = 1, RegWrite = 0.
- Illegal instructions:
  - 0xFC000000 -> ex_valid = 0, ill_count = 1.
  - 0x00000001 (bad funct) -> ill_count = 2.
  - After 300 illegal instructions, ill_count = 0xFF.
  - An illegal instruction presented together with flush -> count unchanged.
- Priority checks:
  - stall = 1 with a new instruction -> ex_* outputs unchanged.
  - flush and stall together -> bubble.
  - Reset pulsed asynchronously mid-cycle -> all outputs 0 before the next edge.
